// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds and a standard or FWFT read port.
// Optional build macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow flags; without it both outputs are tied low and no flag
// registers are built.
module sync_fifo_param #(
  parameter int DATA_LEN = 16,
  parameter int ADDR_LEN = 4,
  parameter int AF_LEVEL = (1 << ADDR_LEN) - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                wrt_en,
  output logic                wrt_full,
  output logic                almost_full,
  output logic [DATA_LEN-1:0] data_out,
  input  logic                rd_en,
  output logic                rd_empty,
  output logic                almost_empty,
  output logic [ADDR_LEN:0]   count,
  output logic                overflow,
  output logic                underflow
);

  // Depth is derived from the pointer width and cannot be overridden.
  localparam int FIFO_DEPTH = 1 << ADDR_LEN;

  localparam logic [ADDR_LEN:0] DEPTH_C = (ADDR_LEN+1)'(FIFO_DEPTH);
  localparam logic [ADDR_LEN:0] AF_C    = (ADDR_LEN+1)'(AF_LEVEL);
  localparam logic [ADDR_LEN:0] AE_C    = (ADDR_LEN+1)'(AE_LEVEL);

  logic [DATA_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_LEN-1:0] wptr_q, wptr_d;
  logic [ADDR_LEN-1:0] rptr_q, rptr_d;
  logic [ADDR_LEN:0]   count_q, count_d;
  logic                full, empty;
  logic                wr_acc, rd_acc;

  // Flags come from the registered count only.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign wrt_full     = full;
  assign rd_empty     = empty;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // Accept decisions use the occupancy at the start of the cycle.
  assign wr_acc = wrt_en & ~full;
  assign rd_acc = rd_en & ~empty;

  // Next-state pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_acc) wptr_d = wptr_q + ADDR_LEN'(1);
    if (rd_acc) rptr_d = rptr_q + ADDR_LEN'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_LEN+1)'(1);
      2'b01:   count_d = count_q - (ADDR_LEN+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented directly; forced to zero while empty so the
      // port reads 0 out of reset.
      assign data_out = empty ? '0 : mem_q[rptr_q];
    end else begin : g_std
      logic [DATA_LEN-1:0] dout_q, dout_d;

      // Head word is captured only on an accepted read, otherwise held.
      always_comb begin
        dout_d = dout_q;
        if (rd_acc) dout_d = mem_q[rptr_q];
      end

      // Registered read-data port.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dout_q <= '0;
        else          dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; only reset clears them.
  always_comb begin
    ovf_d = ovf_q | (wrt_en & full);
    unf_d = unf_q | (rd_en & empty);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
